// File: rtl/desc_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : desc_serializer_pkg
// Purpose  : Shared ORB widths and serializer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package desc_serializer_pkg;

    localparam int WIDTH_PIXEL       = 8;
    localparam int WIDTH_DESCRIPTORS = 256;
    localparam int WIDTH_WORD        = 32;
    localparam int WORDS_PER_DESC    = WIDTH_DESCRIPTORS / WIDTH_WORD;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage
`default_nettype wire

// File: rtl/desc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : desc_fifo
// Purpose  : DEPTH x WIDTH descriptor FIFO with level, full and empty flags.
//            The caller only pushes when not full or when popping together.
// Revision : 1.0 - initial release
// ============================================================================
module desc_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 256,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    // Next pointers, level and storage contents; pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; only slots behind valid pointers are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;
    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);

endmodule
`default_nettype wire

// File: rtl/desc_serializer.sv
`default_nettype none
// ============================================================================
// Module   : desc_serializer
// Purpose  : Buffers descriptors and emits them MSB word first on a
//            valid/ready word stream; counts descriptors dropped when full.
// Revision : 1.0 - initial release
// ============================================================================
module desc_serializer
    import desc_serializer_pkg::*;
#(
    parameter  int WIDTH_DESCRIPTORS = desc_serializer_pkg::WIDTH_DESCRIPTORS,
    parameter  int WIDTH_WORD        = desc_serializer_pkg::WIDTH_WORD,
    parameter  int DEPTH             = 4,
    localparam int LVL_W             = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH_DESCRIPTORS-1:0] desc_in,
    input  logic                         desc_valid,
    output logic [WIDTH_WORD-1:0]        word_out,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic                         word_last,
    output logic [LVL_W-1:0]             fifo_level,
    output logic                         overflow,
    output logic [15:0]                  drop_count
);

    localparam int WORDS = WIDTH_DESCRIPTORS / WIDTH_WORD;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    ser_state_e                   state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic                         overflow_q, overflow_d;
    logic [15:0]                  drop_count_q, drop_count_d;

    logic                         fifo_push;
    logic                         fifo_pop;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [LVL_W-1:0]             fifo_lvl;
    logic [WIDTH_DESCRIPTORS-1:0] head;
    logic [WIDTH_WORD-1:0]        head_words [WORDS];
    logic                         xfer;
    logic                         drop;

    desc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH_DESCRIPTORS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (desc_in),
        .dout  (head),
        .level (fifo_lvl),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign xfer = word_valid && word_ready;

    // A full FIFO still accepts a descriptor when the head leaves this edge.
    assign fifo_push = desc_valid && (!fifo_full || fifo_pop);
    assign drop      = desc_valid && fifo_full && !fifo_pop;

    // FSM next state, word index and pop decision.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q == IDX_W'(WORDS - 1)) begin
                        fifo_pop = 1'b1;
                        idx_d    = '0;
                        // Leave SEND only if nothing remains after this pop.
                        if (fifo_lvl == LVL_W'(1) && !desc_valid) begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Sticky overflow flag and saturating drop counter.
    always_comb begin
        overflow_d   = overflow_q | drop;
        drop_count_d = drop_count_q;
        if (drop && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    // Split the head descriptor into words, word 0 being the MSB slice.
    always_comb begin
        for (int k = 0; k < WORDS; k++) begin
            head_words[k] = head[WIDTH_DESCRIPTORS - 1 - k * WIDTH_WORD -: WIDTH_WORD];
        end
    end

    // Control registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Outputs derive from registered state, so reset zeroes them at once.
    assign word_valid = (state_q == SEND);
    assign word_last  = (state_q == SEND) && (idx_q == IDX_W'(WORDS - 1));
    assign word_out   = (state_q == SEND) ? head_words[idx_q] : '0;
    assign fifo_level = fifo_lvl;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_desc_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_desc_serializer
// Purpose  : Directed self-checking bench for desc_serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_desc_serializer;

    localparam int W     = 256;
    localparam int WW    = 32;
    localparam int WORDS = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  desc_in = '0;
    logic          desc_valid = 1'b0;
    logic          word_ready = 1'b0;
    logic [WW-1:0] word_out;
    logic          word_valid;
    logic          word_last;
    logic [2:0]    fifo_level;
    logic          overflow;
    logic [15:0]   drop_count;

    int checks = 0;
    int errors = 0;

    desc_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .desc_in    (desc_in),
        .desc_valid (desc_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_last  (word_last),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word k of descriptor d; d = 0 gives word k = 32'h1111_1111 * k.
    function automatic logic [WW-1:0] wexp(input int d, input int k);
        return WW'(32'h1111_1111 * k) ^ WW'(32'h0001_0000 * d);
    endfunction

    function automatic logic [W-1:0] mk(input int d);
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < WORDS; k++) v[(WORDS - 1 - k) * WW +: WW] = wexp(d, k);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        desc_valid = 1'b0;
        word_ready = 1'b0;
        desc_in    = 'x;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push(input int d);
        desc_in    = mk(d);
        desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
        desc_in    = 'x;
    endtask

    // Expects all words of descriptor d with word_ready held high.
    task automatic expect_desc(input int d);
        int guard;
        for (int k = 0; k < WORDS; k++) begin
            guard = 0;
            while (word_valid !== 1'b1 && guard < 20) begin
                step();
                guard++;
            end
            check($sformatf("d%0d_valid%0d", d, k), word_valid, 1'b1);
            check($sformatf("d%0d_word%0d", d, k), word_out, wexp(d, k));
            check($sformatf("d%0d_last%0d", d, k), word_last, (k == WORDS - 1));
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int           got;
        int           cyc;
        bit           stalled;
        logic [WW-1:0] held;
        logic         held_last;
        logic [W-1:0] rec;

        // Reset state
        step();
        check("rst_valid", word_valid, 1'b0);
        check("rst_last", word_last, 1'b0);
        check("rst_word", word_out, '0);
        check("rst_level", fifo_level, '0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_drops", drop_count, '0);
        rst = 1'b0;

        // Single descriptor, first edge after reset release, ready held 1
        word_ready = 1'b1;
        push(0);
        check("s1_lat_valid", word_valid, 1'b0);
        check("s1_lat_level", fifo_level, 3'd1);
        step();
        for (int k = 0; k < WORDS; k++) begin
            check($sformatf("s1_valid%0d", k), word_valid, 1'b1);
            check($sformatf("s1_word%0d", k), word_out, WW'(32'h1111_1111 * k));
            check($sformatf("s1_last%0d", k), word_last, (k == WORDS - 1));
            step();
        end
        check("s1_idle_valid", word_valid, 1'b0);
        check("s1_idle_level", fifo_level, 3'd0);

        // Backpressure: ready pattern 1,0,0,1
        do_reset();
        push(1);
        got = 0; cyc = 0; stalled = 0; rec = '0; held = '0; held_last = 1'b0;
        while (got < WORDS && cyc < 80) begin
            word_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (word_valid) begin
                if (stalled) begin
                    check("bp_hold_word", word_out, held);
                    check("bp_hold_last", word_last, held_last);
                end
                if (word_ready) begin
                    rec[(WORDS - 1 - got) * WW +: WW] = word_out;
                    check("bp_last", word_last, (got == WORDS - 1));
                    got++;
                    stalled = 0;
                end else begin
                    stalled   = 1;
                    held      = word_out;
                    held_last = word_last;
                end
            end
            step();
            cyc++;
        end
        word_ready = 1'b0;
        check("bp_count", got, WORDS);
        check("bp_desc", rec, mk(1));
        check("bp_level", fifo_level, 3'd0);

        // Burst of 6 into a depth-4 FIFO with ready low
        do_reset();
        for (int i = 0; i < 6; i++) begin
            desc_in    = mk(10 + i);
            desc_valid = 1'b1;
            step();
        end
        desc_valid = 1'b0;
        desc_in    = 'x;
        check("burst_level", fifo_level, 3'd4);
        check("burst_ovf", overflow, 1'b1);
        check("burst_drops", drop_count, 16'd2);
        word_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_desc(10 + i);
        check("burst_end_level", fifo_level, 3'd0);
        check("burst_end_valid", word_valid, 1'b0);

        // Full FIFO with push on the same edge as the last-word pop
        do_reset();
        for (int i = 0; i < 4; i++) begin
            desc_in    = mk(20 + i);
            desc_valid = 1'b1;
            step();
        end
        desc_valid = 1'b0;
        desc_in    = 'x;
        check("fp_level_full", fifo_level, 3'd4);
        word_ready = 1'b1;
        for (int k = 0; k < WORDS; k++) begin
            check($sformatf("fp_word%0d", k), word_out, wexp(20, k));
            if (k == WORDS - 1) begin
                desc_in    = mk(24);
                desc_valid = 1'b1;
            end
            step();
        end
        desc_valid = 1'b0;
        desc_in    = 'x;
        check("fp_level_hold", fifo_level, 3'd4);
        check("fp_drops", drop_count, 16'd0);
        check("fp_ovf", overflow, 1'b0);
        for (int i = 1; i < 5; i++) expect_desc(20 + i);
        check("fp_end_level", fifo_level, 3'd0);

        // Reset after three words of eight have transferred
        do_reset();
        word_ready = 1'b1;
        push(30);
        step();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rm_word%0d", k), word_out, wexp(30, k));
            step();
        end
        check("rm_word3", word_out, wexp(30, 3));
        #1 rst = 1'b1;
        #1;
        check("rm_async_valid", word_valid, 1'b0);
        check("rm_async_last", word_last, 1'b0);
        check("rm_async_word", word_out, '0);
        check("rm_async_level", fifo_level, '0);
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("rm_post_valid%0d", i), word_valid, 1'b0);
        end

        // Drop counter saturation
        do_reset();
        for (int i = 0; i < 4; i++) begin
            desc_in    = mk(40 + i);
            desc_valid = 1'b1;
            step();
        end
        desc_valid = 1'b0;
        force dut.drop_count_q = 16'hFFFE;
        #1;
        release dut.drop_count_q;
        desc_in    = mk(44);
        desc_valid = 1'b1;
        step();
        check("sat_first", drop_count, 16'hFFFF);
        step();
        step();
        desc_valid = 1'b0;
        desc_in    = 'x;
        check("sat_drops", drop_count, 16'hFFFF);
        check("sat_ovf", overflow, 1'b1);
        check("sat_level", fifo_level, 3'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
